branch_cond_unit: RTL and testbench
===================================

// Module: branch_cond_unit
// PURPOSE
//  Consumer end of the shifter/ALU condition-code interface for the 16-bit SIMPLE pipeline.
//  - Holds the architectural flag register {S,Z,C,V} = bits [3:0], written from the
//    shifter/ALU Outcond bus.
//  - Evaluates branch conditions against those flags and issues a registered PC redirect.
//  - Squashes younger instructions by driving a flush pulse for FLUSH_CYCLES cycles.
// PARAMETERS
//  PC_W          16  width of PC and branch target
//  FLUSH_CYCLES  2   cycles flush stays high after a taken branch (legal range 1..7)
// PORTS
//  clk             in   1     system clock, rising edge
//  rst_n           in   1     asynchronous active-low reset
//  stall           in   1     pipeline hold; freezes all state when high
//  flag_we         in   1     write flag_in into flag register this cycle
//  flag_in         in   4     {S,Z,C,V} from shifter/ALU
//  br_valid        in   1     branch instruction present in resolve stage
//  br_uncond       in   1     unconditional branch (B); ignores br_cond
//  br_cond         in   3     0=BE 1=BLT 2=BLE 3=BNE; 4..7 reserved -> never taken
//  br_target       in   PC_W  branch destination
//  redirect_valid  out  1     one-cycle pulse: fetch must load redirect_pc
//  redirect_pc     out  PC_W  registered target
//  flush           out  1     squash younger stages
//  flags_out       out  4     current flag register
// BEHAVIOUR
//  Reset
//  - rst_n low: flags=4'b0000, redirect_valid=0, redirect_pc=0, flush=0, FSM=IDLE.
//  - Reset is asynchronous and overrides everything, including mid-flush; FSM returns to IDLE.
//  Flag register
//  - On a clock edge with flag_we=1 and stall=0: flags <= flag_in.
//  Effective flags (used for branch evaluation)
//  - eff = flag_we ? flag_in : flags (same-cycle bypass; combinational).
//  Conditions (S=eff[3], Z=eff[2], V=eff[0])
//  - BE  = Z
//  - BLT = S^V
//  - BLE = Z | (S^V)
//  - BNE = ~Z
//  - Reserved codes 4..7 = 0.
//  - taken = br_valid & (br_uncond | cond) & (state==IDLE) & ~stall.
//  FSM
//  - IDLE:
//    - If taken: next edge sets redirect_valid=1, redirect_pc=br_target, flush=1,
//      cnt=FLUSH_CYCLES-1, go to FLUSH.
//    - Otherwise outputs stay low (redirect_pc holds its last value).
//  - FLUSH:
//    - redirect_valid=0 after its single cycle; flush stays 1.
//    - cnt decrements each unstalled cycle. When cnt==0 at an edge: flush<=0, go to IDLE.
//    - br_valid is ignored in FLUSH (the instruction is being squashed). Flag writes still apply.
//  - FLUSH_CYCLES=1: flush is high for exactly the redirect cycle, then IDLE.
//  Latency and timing
//  - Latency: branch at edge N -> redirect_valid/flush high during cycle N+1.
//  - Total flush high = FLUSH_CYCLES unstalled cycles.
//  Stall
//  - stall=1 freezes flags, FSM, cnt, redirect_pc and flush.
//  - A pending redirect_valid stays high until the first unstalled edge.
//  Width
//  - No arithmetic on the PC; redirect_pc is a straight register of br_target.
// TESTING
//  T1 reset mid-flush:
//   - Drive rst_n low during FLUSH -> flush=0, redirect_valid=0, flags=0 immediately,
//     without waiting for a clock edge.
//  T2 BE bypass:
//   - Stimulus: flags=0; same cycle flag_we=1, flag_in=4'b0100, br_valid=1, br_cond=0,
//     br_target=16'h0040.
//   - Required: next cycle redirect_valid=1, redirect_pc=16'h0040, flush=1.
//   - Required: flush high 2 cycles, then 0.
//  T3 BLT, S/V disagree:
//   - flags=4'b1000, br_cond=1 -> taken.
//   - flags=4'b1001, br_cond=1 -> not taken; redirect_valid and flush stay 0.
//  T4 branch in FLUSH plus reserved code:
//   - B taken, then br_valid=1 with br_uncond=1 in the next cycle -> ignored, one redirect only.
//   - br_cond=5 while IDLE -> never taken.
//  T5 stall:
//   - Assert stall=1 for 3 cycles while redirect_valid=1 -> redirect_valid held 3 cycles.
//   - flush total high = 2 + 3 cycles; flag_we during stall is not applied.
//  T6 BLE/BNE sweep:
//   - All 16 flag values x cond 0..7; compare taken against the equations above.

Source files
------------

// File: rtl/branch_cond_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cond_unit
//  Description : Branch resolution for the 16-bit SIMPLE pipeline. Holds the
//                architectural {S,Z,C,V} flag register written from the
//                shifter/ALU condition bus, evaluates branch conditions
//                against those flags (with same-cycle bypass of a flag
//                write), issues a registered one-cycle PC redirect and
//                holds a flush pulse for FLUSH_CYCLES unstalled cycles.
//
//  Ports       : clk             in   system clock, rising edge
//                rst_n           in   asynchronous active-low reset
//                stall           in   pipeline hold; freezes all state
//                flag_we         in   write flag_in into the flag register
//                flag_in   [3:0] in   {S,Z,C,V} from shifter/ALU
//                br_valid        in   branch present in resolve stage
//                br_uncond       in   unconditional branch, ignores br_cond
//                br_cond   [2:0] in   0=BE 1=BLT 2=BLE 3=BNE, 4..7 never
//                br_target [PC_W-1:0] in  branch destination
//                redirect_valid  out  one-cycle fetch redirect pulse
//                redirect_pc     out  registered branch target
//                flush           out  squash younger stages
//                flags_out [3:0] out  current flag register
//
//  Revision    : 1.0  initial release
// ============================================================================
module branch_cond_unit #(
    parameter int unsigned PC_W         = 16,
    parameter int unsigned FLUSH_CYCLES = 2     // legal range 1..7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flag_we,
    input  logic [3:0]      flag_in,
    input  logic            br_valid,
    input  logic            br_uncond,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush,
    output logic [3:0]      flags_out
);

    // Counter is loaded with FLUSH_CYCLES-1 because the redirect cycle
    // itself is the first flush cycle.
    localparam logic [2:0] c_cnt_init = 3'(FLUSH_CYCLES - 1);

    localparam logic [2:0] c_cond_be  = 3'd0;
    localparam logic [2:0] c_cond_blt = 3'd1;
    localparam logic [2:0] c_cond_ble = 3'd2;
    localparam logic [2:0] c_cond_bne = 3'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t          r_state;
    logic [2:0]      r_cnt;
    logic [3:0]      r_flags;
    logic            r_redirect_valid;
    logic [PC_W-1:0] r_redirect_pc;
    logic            r_flush;

    state_t          w_state_nxt;
    logic [2:0]      w_cnt_nxt;
    logic [3:0]      w_flags_nxt;
    logic            w_redirect_valid_nxt;
    logic [PC_W-1:0] w_redirect_pc_nxt;
    logic            w_flush_nxt;

    logic [3:0]      w_eff;
    logic            w_s;
    logic            w_z;
    logic            w_v;
    logic            w_cond;
    logic            w_taken;

    // ------------------------------------------------------------------
    // Condition evaluation. A flag write in the same cycle as the branch
    // is forwarded so compare-and-branch pairs need no bubble.
    // ------------------------------------------------------------------
    always_comb begin
        w_eff = flag_we ? flag_in : r_flags;
        w_s   = w_eff[3];
        w_z   = w_eff[2];
        w_v   = w_eff[0];
        w_cond = 1'b0;
        case (br_cond)
            c_cond_be:  w_cond = w_z;
            c_cond_blt: w_cond = w_s ^ w_v;
            c_cond_ble: w_cond = w_z | (w_s ^ w_v);
            c_cond_bne: w_cond = ~w_z;
            default:    w_cond = 1'b0;
        endcase
        w_taken = br_valid & (br_uncond | w_cond)
                & (r_state == ST_IDLE) & ~stall;
    end

    // ------------------------------------------------------------------
    // Next-state logic. Everything holds by default; a stall simply
    // skips all updates.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt          = r_state;
        w_cnt_nxt            = r_cnt;
        w_flags_nxt          = r_flags;
        w_redirect_valid_nxt = r_redirect_valid;
        w_redirect_pc_nxt    = r_redirect_pc;
        w_flush_nxt          = r_flush;

        if (!stall) begin
            if (flag_we) begin
                w_flags_nxt = flag_in;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_taken) begin
                        w_redirect_valid_nxt = 1'b1;
                        w_redirect_pc_nxt    = br_target;
                        w_flush_nxt          = 1'b1;
                        w_cnt_nxt            = c_cnt_init;
                        w_state_nxt          = ST_FLUSH;
                    end else begin
                        w_redirect_valid_nxt = 1'b0;
                        w_flush_nxt          = 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // Branches arriving here are being squashed: ignore them.
                    w_redirect_valid_nxt = 1'b0;
                    if (r_cnt == 3'd0) begin
                        w_flush_nxt = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_redirect_valid_nxt = 1'b0;
                    w_flush_nxt          = 1'b0;
                    w_state_nxt          = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_cnt            <= 3'd0;
            r_flags          <= 4'b0000;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_flags          <= w_flags_nxt;
            r_redirect_valid <= w_redirect_valid_nxt;
            r_redirect_pc    <= w_redirect_pc_nxt;
            r_flush          <= w_flush_nxt;
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_flush;
    assign flags_out      = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_branch_cond_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_cond_unit
//  Description : Directed self-checking bench for branch_cond_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_cond_unit;

    localparam int unsigned PC_W = 16;

    logic            clk;
    logic            rst_n;
    logic            stall;
    logic            flag_we;
    logic [3:0]      flag_in;
    logic            br_valid;
    logic            br_uncond;
    logic [2:0]      br_cond;
    logic [PC_W-1:0] br_target;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            flush;
    logic [3:0]      flags_out;

    int n_cmp;
    int n_err;

    branch_cond_unit #(
        .PC_W         (PC_W),
        .FLUSH_CYCLES (2)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flag_we        (flag_we),
        .flag_in        (flag_in),
        .br_valid       (br_valid),
        .br_uncond      (br_uncond),
        .br_cond        (br_cond),
        .br_target      (br_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .flags_out      (flags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall     = 1'b0;
        flag_we   = 1'b0;
        br_valid  = 1'b0;
        br_uncond = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic rv, input logic fl);
        check({tag, ".rv"},    {31'd0, redirect_valid}, {31'd0, rv});
        check({tag, ".flush"}, {31'd0, flush},          {31'd0, fl});
    endtask

    function automatic logic model_cond(input logic [3:0] f, input logic [2:0] c);
        logic s, z, v;
        s = f[3];
        z = f[2];
        v = f[0];
        case (c)
            3'd0:    return z;
            3'd1:    return s ^ v;
            3'd2:    return z | (s ^ v);
            3'd3:    return ~z;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        stall     = 1'b0;
        flag_we   = 1'b0;
        flag_in   = 4'b0000;
        br_valid  = 1'b0;
        br_uncond = 1'b0;
        br_cond   = 3'd0;
        br_target = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_outs("reset", 1'b0, 1'b0);
        check("reset.pc",    {16'd0, redirect_pc}, 32'h0);
        check("reset.flags", {28'd0, flags_out},   32'h0);
        rst_n = 1'b1;
        tick();

        // ---------------- T2: BE with same-cycle flag bypass ----------------
        flag_we   = 1'b1;
        flag_in   = 4'b0100;
        br_valid  = 1'b1;
        br_cond   = 3'd0;
        br_target = 16'h0040;
        tick();
        idle_inputs();
        check_outs("t2.c1", 1'b1, 1'b1);
        check("t2.pc",    {16'd0, redirect_pc}, 32'h0040);
        check("t2.flags", {28'd0, flags_out},   32'h4);
        tick();
        check_outs("t2.c2", 1'b0, 1'b1);
        tick();
        check_outs("t2.c3", 1'b0, 1'b0);

        // ---------------- T3: BLT from the flag register ----------------
        flag_we = 1'b1;
        flag_in = 4'b1000;
        tick();
        flag_we   = 1'b0;
        flag_in   = 4'b0000;     // ignored: flag_we is low
        br_valid  = 1'b1;
        br_cond   = 3'd1;
        br_target = 16'h1234;
        tick();
        idle_inputs();
        check_outs("t3.taken", 1'b1, 1'b1);
        check("t3.pc", {16'd0, redirect_pc}, 32'h1234);
        tick();
        tick();
        check_outs("t3.drain", 1'b0, 1'b0);
        flag_we = 1'b1;
        flag_in = 4'b1001;
        tick();
        flag_we   = 1'b0;
        br_valid  = 1'b1;
        br_cond   = 3'd1;
        br_target = 16'h5555;
        tick();
        idle_inputs();
        check_outs("t3.nottaken", 1'b0, 1'b0);
        check("t3.pchold", {16'd0, redirect_pc}, 32'h1234);

        // ---------------- T4: branch during FLUSH, reserved code ----------------
        br_valid  = 1'b1;
        br_uncond = 1'b1;
        br_cond   = 3'd5;
        br_target = 16'h0100;
        tick();
        check_outs("t4.first", 1'b1, 1'b1);
        br_target = 16'h0200;        // second B while flushing
        tick();
        idle_inputs();
        check_outs("t4.ignored", 1'b0, 1'b1);
        check("t4.pc", {16'd0, redirect_pc}, 32'h0100);
        tick();
        check_outs("t4.drain", 1'b0, 1'b0);
        br_valid  = 1'b1;
        br_uncond = 1'b0;
        br_cond   = 3'd5;
        br_target = 16'h0300;
        tick();
        idle_inputs();
        check_outs("t4.reserved", 1'b0, 1'b0);

        // ---------------- T5: stall holds redirect and flush ----------------
        br_valid  = 1'b1;
        br_uncond = 1'b1;
        br_target = 16'h0400;
        tick();
        idle_inputs();
        check_outs("t5.c0", 1'b1, 1'b1);
        stall   = 1'b1;
        flag_we = 1'b1;
        flag_in = 4'b1111;
        tick();
        check_outs("t5.s1", 1'b1, 1'b1);
        check("t5.flags", {28'd0, flags_out}, 32'h9);
        tick();
        check_outs("t5.s2", 1'b1, 1'b1);
        tick();
        check_outs("t5.s3", 1'b1, 1'b1);
        stall   = 1'b0;
        flag_we = 1'b0;
        tick();
        check_outs("t5.post1", 1'b0, 1'b1);
        tick();
        check_outs("t5.post2", 1'b0, 1'b0);
        check("t5.flagsfinal", {28'd0, flags_out}, 32'h9);
        // stall also blocks a branch in IDLE
        stall    = 1'b1;
        br_valid = 1'b1;
        br_uncond = 1'b1;
        tick();
        idle_inputs();
        check_outs("t5.stallidle", 1'b0, 1'b0);

        // ---------------- T1: asynchronous reset mid-flush ----------------
        flag_we   = 1'b1;
        flag_in   = 4'b0110;
        br_valid  = 1'b1;
        br_uncond = 1'b1;
        br_target = 16'h0abc;
        tick();
        idle_inputs();
        check_outs("t1.pre", 1'b1, 1'b1);
        check("t1.preflags", {28'd0, flags_out}, 32'h6);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("t1.async", 1'b0, 1'b0);
        check("t1.flags", {28'd0, flags_out},   32'h0);
        check("t1.pc",    {16'd0, redirect_pc}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check_outs("t1.idle", 1'b0, 1'b0);

        // ---------------- T6: full flag x condition sweep ----------------
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 8; c++) begin
                logic [3:0] fv;
                logic [2:0] cv;
                fv = 4'(f);
                cv = 3'(c);
                // Odd conditions use the bypass path, even use the register.
                if (c % 2 == 0) begin
                    flag_we = 1'b1;
                    flag_in = fv;
                    tick();
                    flag_we = 1'b0;
                    flag_in = ~fv;
                end else begin
                    flag_we = 1'b1;
                    flag_in = fv;
                end
                br_valid  = 1'b1;
                br_uncond = 1'b0;
                br_cond   = cv;
                br_target = {8'h00, fv, 1'b0, cv};
                tick();
                idle_inputs();
                check($sformatf("t6.f%0d.c%0d", f, c),
                      {31'd0, redirect_valid}, {31'd0, model_cond(fv, cv)});
                tick();
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
